// File: rtl/bus_scan_reader.sv
// bus_scan_reader
//   Reader side of the shared tri-state register bus. Walks the holding
//   registers in ascending index order: pulls one chip-select low, waits
//   SettleCycles Tick-qualified cycles for the bus to settle, captures the
//   bus, then offers the value downstream. After the last register is
//   accepted, done pulses for one cycle and the block returns to idle.
//
//   Optional build macro: SCAN_MASK_EN
//     Adds scan_mask, which is sampled when a scan starts. Registers whose
//     mask bit is 0 are skipped. An all-zero mask produces only a done pulse.
//
// Ports
//   Clock      in   system clock; all state changes on the rising edge
//   Reset      in   asynchronous active-low reset
//   Tick       in   clock-enable qualifier for start and for settle counting
//   start      in   request a full scan; sampled only in IDLE with Tick=1
//   scan_mask  in   per-register enable (present only with SCAN_MASK_EN)
//   bus_in     in   resolved value of the shared bus
//   cs_n       out  per-register chip-select; 0 = register drives the bus
//   out_data   out  captured register value; held after the beat is taken
//   out_index  out  index of the register that out_data came from
//   out_valid  out  out_data/out_index valid
//   out_ready  in   downstream ready
//   out_last   out  out_valid on the final beat of the scan
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the final handshake
//
// Handshake: a beat transfers on any rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data and out_index
// stay stable until that transfer. out_ready has no Tick qualification.

module bus_scan_reader #(
    parameter int NrOfBits     = 8,
    parameter int NrOfRegs     = 4,
    parameter int SettleCycles = 1,
    parameter int IdxBits      = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                start,
`ifdef SCAN_MASK_EN
    input  logic [NrOfRegs-1:0] scan_mask,
`endif
    input  logic [NrOfBits-1:0] bus_in,
    output logic [NrOfRegs-1:0] cs_n,
    output logic [NrOfBits-1:0] out_data,
    output logic [IdxBits-1:0]  out_index,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam int CntBits = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [CntBits-1:0] CntLast = CntBits'(SettleCycles - 1);
    localparam logic [IdxBits-1:0] IdxLast = IdxBits'(NrOfRegs - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IdxBits-1:0]    idx_q, idx_d;
    logic [CntBits-1:0]    cnt_q, cnt_d;
    logic [NrOfBits-1:0]   data_q, data_d;
    logic [IdxBits-1:0]    index_q, index_d;
    logic                  valid_q, valid_d;

`ifdef SCAN_MASK_EN
    logic [NrOfRegs-1:0]   mask_q, mask_d;
    logic [IdxBits:0]      first_hit;  // {found, position} from scan_mask
    logic [IdxBits:0]      next_hit;   // next set bit above idx_q
    logic [IdxBits:0]      above_hit;  // any set bit above out_index

    // Lowest set bit of m at or above position from. MSB of the result
    // says whether one was found; the rest is its position.
    function automatic logic [IdxBits:0] next_set(input logic [NrOfRegs-1:0] m,
                                                  input int from);
        logic               found;
        logic [IdxBits-1:0] pos;
        found = 1'b0;
        pos   = '0;
        for (int i = NrOfRegs - 1; i >= 0; i--) begin
            if (i >= from && m[i]) begin
                found = 1'b1;
                pos   = IdxBits'(i);
            end
        end
        return {found, pos};
    endfunction

    always_comb begin
        first_hit = next_set(scan_mask, 0);
        next_hit  = next_set(mask_q, int'(idx_q) + 1);
        above_hit = next_set(mask_q, int'(index_q) + 1);
    end
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
`ifdef SCAN_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
`ifdef SCAN_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        index_d = index_q;
        valid_d = valid_q;
`ifdef SCAN_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && Tick) begin
                    cnt_d = '0;
`ifdef SCAN_MASK_EN
                    mask_d = scan_mask;
                    if (first_hit[IdxBits]) begin
                        idx_d   = first_hit[IdxBits-1:0];
                        state_d = ST_SELECT;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end
`else
                    idx_d   = '0;
                    state_d = ST_SELECT;
`endif
                end
            end
            ST_SELECT: begin
                if (Tick) begin
                    if (cnt_q == CntLast) begin
                        data_d  = bus_in;
                        index_d = idx_q;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
`ifdef SCAN_MASK_EN
                    if (next_hit[IdxBits]) begin
                        idx_d   = next_hit[IdxBits-1:0];
                        cnt_d   = '0;
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    if (idx_q == IdxLast) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                        state_d = ST_SELECT;
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Only SELECT enables a driver, so at most one cs_n bit is ever low and
    // the bus is released in the same instant that reset pulls state to IDLE.
    always_comb begin
        cs_n = '1;
        if (state_q == ST_SELECT) begin
            cs_n[idx_q] = 1'b0;
        end
    end

    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

`ifdef SCAN_MASK_EN
    assign out_last = valid_q & ~above_hit[IdxBits];
`else
    assign out_last = valid_q & (index_q == IdxLast);
`endif

endmodule
